s2_pipe: RTL
============

Name: s2_pipe

Overview:
- Parametrised successor to the single-stage S2 logic-module cell.
- Selects one of 2^K N-bit data words using K gated select bits. Each select bit is the AND or the OR of an A/B input pair, chosen per bit.
- The selected word passes through a DEPTH-stage pipeline with valid/ready backpressure and a synchronous flush.
- Used wherever a chain of S2-style registered muxes feeds a consumer that can stall.

Parameters:
- N, 8: data width per channel.
- K, 2: number of select bits; the block has 2^K data channels.
- OPMASK, 2'b10 (K bits): per select bit, 1 = OR (S[i] = A[i] | B[i]), 0 = AND (S[i] = A[i] & B[i]). The default reproduces S1 = A1|B1, S0 = A0&B0.
- DEPTH, 2: number of pipeline stages, 1..8.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- clr  in  1  reset; asynchronous, active-low (0 = reset).
- flush  in  1  synchronous flush; active-high.
- D  in  N*2^K  packed data; channel c occupies D[c*N +: N].
- A  in  K  select operand A.
- B  in  K  select operand B.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept the input this cycle.
- out_data  out  N  head-of-pipeline data.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts out_data.
- occ  out  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- Select: S[i] = OPMASK[i] ? (A[i] | B[i]) : (A[i] & B[i]). RM = D[S*N +: N]. Fully combinational, sampled only at input acceptance.
- Stages 0..DEPTH-1 each hold vld[j] and dat[j]; stage DEPTH-1 drives out_valid/out_data.
- Ready chain: rdy[DEPTH] = out_ready; rdy[j] = !vld[j] | rdy[j+1]; in_ready = rdy[0]. Combinational, no registered ready.
- Stage 0 loads RM and vld[0] <= in_valid when rdy[0].
- Stage j>0 loads dat[j-1]/vld[j-1] when rdy[j].
- A stage not loading holds its contents.
- Input accepted iff in_valid & in_ready. Output consumed iff out_valid & out_ready.
- Latency: DEPTH cycles from acceptance to out_valid with no stall. Throughput 1 word/cycle.
- Backpressure:
  - With out_ready=0, bubbles collapse.
  - in_ready stays 1 until all DEPTH stages are valid, then drops.
  - No word is lost or duplicated.
- Data in invalid stages holds its last value; it is not cleared.
- occ: registered count; +1 on accept, -1 on consume, unchanged when both or neither occur. Range 0..DEPTH.
- flush=1:
  - Next edge clears all vld and sets occ to 0.
  - Dominates in_valid; a word presented that cycle is dropped.
  - in_ready is still reported per the ready chain.
  - dat is unchanged.
- Reset (clr=0, async): all vld=0, all dat=0, occ=0. Hence out_valid=0, out_data=0.
- Reset mid-stream discards all words. The first cycle after release behaves as empty: in_ready=1.
- Inputs are ignored while clr=0.

Optional Feature:
- Macro: S2_PIPE_SEL_OUT_EN.
- Defined:
  - Adds port sel_out (out, K): the select value S captured with each word.
  - Travels through the pipeline aligned with out_data.
  - Reset value 0; not cleared by flush.
- Undefined: no sel_out port and no select registers; all other behaviour is identical.

Test Plan:
- Defaults, clr released, D = {8'hDD, 8'hCC, 8'hBB, 8'hAA}:
  - A=2'b00, B=2'b00 (S=0) -> out_data=8'hAA, 2 cycles after accept.
  - A=2'b01, B=2'b01 (S=1) -> 8'hBB.
  - A=2'b10, B=2'b00 (S=2) -> 8'hCC.
  - A=2'b11, B=2'b01 (S=3) -> 8'hDD.
- Streaming: in_valid=1 for 6 cycles, out_ready=1, S cycling 0..3 -> outputs AA, BB, CC, DD, AA, BB on consecutive cycles starting at cycle 2; in_ready stays 1; occ stays 2 in steady state.
- Stall: out_ready=0, push 3 words -> in_ready=0 after 2 accepted, occ=2, out_data holds the first word. Then out_ready=1 -> words emerge in order, none lost.
- Flush: occ=2 with in_valid=1 and flush=1 -> next cycle out_valid=0, occ=0, the presented word is not emitted.
- Async reset: drive clr=0 between clock edges while occ=2 -> out_valid=0, out_data=0, occ=0 immediately. After release, first accept appears after DEPTH cycles.
- With S2_PIPE_SEL_OUT_EN defined, OPMASK=2'b11, A=2'b00, B=2'b10 -> S=2, sel_out=2'b10 aligned with out_data=8'hCC.

Source files
------------

// File: rtl/s2_pipe.sv
// s2_pipe: gated-select 2^K:1 word mux feeding a DEPTH-stage valid/ready pipeline with flush.
// Optional feature S2_PIPE_SEL_OUT_EN adds sel_out, the select value carried alongside each word.
module s2_pipe #(
  parameter int             N      = 8,
  parameter int             K      = 2,
  parameter logic [K-1:0]   OPMASK = 2'b10,
  parameter int             DEPTH  = 2
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic                         flush,
  input  logic [N*(2**K)-1:0]          D,
  input  logic [K-1:0]                 A,
  input  logic [K-1:0]                 B,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [N-1:0]                 out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   occ
`ifdef S2_PIPE_SEL_OUT_EN
  ,
  output logic [K-1:0]                 sel_out
`endif
);

  localparam int NCH = 2**K;

  logic [K-1:0]     sel;
  logic [N-1:0]     words [NCH];
  logic [N-1:0]     rm;
  logic [DEPTH-1:0] vld;
  logic [N-1:0]     dat [DEPTH];
  logic [DEPTH-1:0] rdy;
  logic             accept;
  logic             consume;

  always_comb begin
    sel = '0;
    for (int i = 0; i < K; i++) begin
      sel[i] = OPMASK[i] ? (A[i] | B[i]) : (A[i] & B[i]);
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_words
    assign words[c] = D[c*N +: N];
  end

  assign rm = words[sel];

  // A stage can load when it or any stage downstream of it holds a bubble,
  // or when the consumer drains the head; written per stage to keep the chain flat.
  for (genvar j = 0; j < DEPTH; j++) begin : g_rdy
    assign rdy[j] = out_ready | ~(&vld[DEPTH-1:j]);
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];
  assign accept    = in_valid & rdy[0];
  assign consume   = vld[DEPTH-1] & out_ready;

  // NOTE: dat is reset too, because out_data must read 0 while clr is asserted;
  // this is a handful of flops, not a RAM, so the reset costs nothing structurally.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      vld <= '0;
      occ <= '0;
      for (int j = 0; j < DEPTH; j++) begin
        dat[j] <= '0;
      end
    end else if (flush) begin
      vld <= '0;
      occ <= '0;
    end else begin
      if (rdy[0]) begin
        vld[0] <= in_valid;
        dat[0] <= rm;
      end
      for (int j = 1; j < DEPTH; j++) begin
        if (rdy[j]) begin
          vld[j] <= vld[j-1];
          dat[j] <= dat[j-1];
        end
      end
      case ({accept, consume})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

`ifdef S2_PIPE_SEL_OUT_EN
  logic [K-1:0] sq [DEPTH];

  // Select tags follow the data registers exactly but survive flush.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int j = 0; j < DEPTH; j++) begin
        sq[j] <= '0;
      end
    end else if (!flush) begin
      if (rdy[0]) begin
        sq[0] <= sel;
      end
      for (int j = 1; j < DEPTH; j++) begin
        if (rdy[j]) begin
          sq[j] <= sq[j-1];
        end
      end
    end
  end

  assign sel_out = sq[DEPTH-1];
`endif

endmodule
